mult_accum_pipe: RTL and testbench

Parametrised, pipelined multiply-add-accumulate for the synthesis elaboration library, and the successor to the single-stage multiply-add primitive. NUM_MULT multipliers feed a per-product add/subtract tree and an optional accumulator. Sample valid flags travel with the data, and a global clock enable stalls the whole pipeline. Saturation or wrap is selectable and an overflow flag is provided. Elaboration maps DSP-style multiply-add/accumulate cells onto this block.

---
 rtl/mult_accum_pipe.sv | 151 +++++++++++++++
 tb/tb_mult_accum_pipe.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_accum_pipe.sv
// rtl/mult_accum_pipe.sv - three-stage multi-lane multiply, add/subtract tree and saturating accumulator
module mult_accum_pipe #(
  parameter int NUM_MULT     = 2,
  parameter int WIDTH_A      = 16,
  parameter int WIDTH_B      = 16,
  parameter int WIDTH_RESULT = 40,
  parameter int SATURATE     = 0
) (
  input  logic                                   clock0,
  input  logic                                   aclr0,
  input  logic                                   ena0,
  input  logic                                   in_valid,
  input  logic [WIDTH_A*NUM_MULT-1:0]            dataa,
  input  logic [WIDTH_B*NUM_MULT-1:0]            datab,
  input  logic                                   signa,
  input  logic                                   signb,
  input  logic [((NUM_MULT > 1) ? NUM_MULT-1 : 1)-1:0] addnsub,
  input  logic                                   accum_en,
  input  logic                                   accum_sload,
  output logic [WIDTH_RESULT-1:0]                result,
  output logic                                   out_valid,
  output logic                                   overflow
);

  localparam int AW = (NUM_MULT > 1) ? NUM_MULT - 1 : 1;
  // Product width holds the exact product of two one-bit-extended operands.
  localparam int PW = WIDTH_A + WIDTH_B + 2;
  // Sum/accumulate width: headroom above the result so the range check never
  // sees a wrapped intermediate, even with four full-scale products.
  localparam int XW = WIDTH_RESULT + 4;
  localparam int WR = WIDTH_RESULT;

  localparam logic signed [XW-1:0] SMAX = $signed({{(XW-WR+1){1'b0}}, {(WR-1){1'b1}}});
  localparam logic signed [XW-1:0] SMIN = $signed({{(XW-WR+1){1'b1}}, {(WR-1){1'b0}}});
  localparam logic signed [XW-1:0] UMAX = $signed({{(XW-WR){1'b0}}, {WR{1'b1}}});

  // Stage 1 registers
  logic [WIDTH_A*NUM_MULT-1:0] a1;
  logic [WIDTH_B*NUM_MULT-1:0] b1;
  logic                        sa1, sb1, ae1, sl1, v1;
  logic [AW-1:0]               as1;

  // Stage 2 registers
  logic signed [PW-1:0] p2 [NUM_MULT];
  logic                 sg2, ae2, sl2, v2;
  logic [AW-1:0]        as2;

  // Combinational datapath
  logic signed [PW-1:0] prod [NUM_MULT];
  logic signed [PW-1:0] ext_a, ext_b;
  logic signed [XW-1:0] term, sum, held, acc_next;
  logic                 over_hi, over_lo;
  logic [WR-1:0]        res_next;

  // Stage 1: capture operands, mode bits and the sample valid flag
  always_ff @(posedge clock0 or negedge aclr0) begin
    if (!aclr0) begin
      a1  <= '0;
      b1  <= '0;
      sa1 <= 1'b0;
      sb1 <= 1'b0;
      as1 <= '0;
      ae1 <= 1'b0;
      sl1 <= 1'b0;
      v1  <= 1'b0;
    end else if (ena0) begin
      a1  <= dataa;
      b1  <= datab;
      sa1 <= signa;
      sb1 <= signb;
      as1 <= addnsub;
      ae1 <= accum_en;
      sl1 <= accum_sload;
      v1  <= in_valid;
    end
  end

  // Per-lane products; each operand gets a sign or zero extension bit, then widened
  always_comb begin
    ext_a = '0;
    ext_b = '0;
    for (int i = 0; i < NUM_MULT; i++) begin
      ext_a = $signed({{(PW-WIDTH_A){sa1 & a1[i*WIDTH_A+WIDTH_A-1]}}, a1[i*WIDTH_A +: WIDTH_A]});
      ext_b = $signed({{(PW-WIDTH_B){sb1 & b1[i*WIDTH_B+WIDTH_B-1]}}, b1[i*WIDTH_B +: WIDTH_B]});
      prod[i] = ext_a * ext_b;
    end
  end

  // Stage 2: register products; only the combined signedness is needed downstream
  always_ff @(posedge clock0 or negedge aclr0) begin
    if (!aclr0) begin
      for (int i = 0; i < NUM_MULT; i++) p2[i] <= '0;
      sg2 <= 1'b0;
      as2 <= '0;
      ae2 <= 1'b0;
      sl2 <= 1'b0;
      v2  <= 1'b0;
    end else if (ena0) begin
      for (int i = 0; i < NUM_MULT; i++) p2[i] <= prod[i];
      sg2 <= sa1 | sb1;
      as2 <= as1;
      ae2 <= ae1;
      sl2 <= sl1;
      v2  <= v1;
    end
  end

  // Add/subtract tree: product 0 is always added, product i follows addnsub bit i-1
  always_comb begin
    term = '0;
    sum  = {{(XW-PW){p2[0][PW-1]}}, p2[0]};
    for (int i = 1; i < NUM_MULT; i++) begin
      term = {{(XW-PW){p2[i][PW-1]}}, p2[i]};
      if (as2[i-1]) sum = sum + term;
      else          sum = sum - term;
    end
  end

  // Accumulate, range-check in this sample's signedness, then clamp or wrap
  always_comb begin
    held     = sg2 ? $signed({{(XW-WR){result[WR-1]}}, result})
                   : $signed({{(XW-WR){1'b0}}, result});
    acc_next = (sl2 || !ae2) ? sum : held + sum;
    if (sg2) begin
      over_hi = acc_next > SMAX;
      over_lo = acc_next < SMIN;
    end else begin
      over_hi = acc_next > UMAX;
      over_lo = acc_next[XW-1];
    end
    if (SATURATE != 0 && over_hi)      res_next = sg2 ? SMAX[WR-1:0] : UMAX[WR-1:0];
    else if (SATURATE != 0 && over_lo) res_next = sg2 ? SMIN[WR-1:0] : '0;
    else                               res_next = acc_next[WR-1:0];
  end

  // Stage 3: result and overflow only move on valid samples; out_valid follows v2
  always_ff @(posedge clock0 or negedge aclr0) begin
    if (!aclr0) begin
      result    <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else if (ena0) begin
      out_valid <= v2;
      if (v2) begin
        result   <= res_next;
        overflow <= over_hi | over_lo;
      end
    end
  end

endmodule

// File: tb/tb_mult_accum_pipe.sv
// tb/tb_mult_accum_pipe.sv - randomized and directed bench for mult_accum_pipe against an arithmetic model
module tb_mult_accum_pipe;

  logic        clock0 = 1'b0;
  logic        aclr0 = 1'b0;
  logic        ena0 = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] dataa = '0;
  logic [31:0] datab = '0;
  logic        signa = 1'b0;
  logic        signb = 1'b0;
  logic [0:0]  addnsub = 1'b0;
  logic        accum_en = 1'b0;
  logic        accum_sload = 1'b0;

  logic [39:0] res40;
  logic [31:0] res32s, res32w;
  logic        vld40, vld32s, vld32w;
  logic        ovf40, ovf32s, ovf32w;

  always #5 clock0 = ~clock0;

  mult_accum_pipe #(.NUM_MULT(2), .WIDTH_A(16), .WIDTH_B(16), .WIDTH_RESULT(40), .SATURATE(0)) dut40 (
    .clock0(clock0), .aclr0(aclr0), .ena0(ena0), .in_valid(in_valid),
    .dataa(dataa), .datab(datab), .signa(signa), .signb(signb), .addnsub(addnsub),
    .accum_en(accum_en), .accum_sload(accum_sload),
    .result(res40), .out_valid(vld40), .overflow(ovf40));

  mult_accum_pipe #(.NUM_MULT(2), .WIDTH_A(16), .WIDTH_B(16), .WIDTH_RESULT(32), .SATURATE(1)) dut32s (
    .clock0(clock0), .aclr0(aclr0), .ena0(ena0), .in_valid(in_valid),
    .dataa(dataa), .datab(datab), .signa(signa), .signb(signb), .addnsub(addnsub),
    .accum_en(accum_en), .accum_sload(accum_sload),
    .result(res32s), .out_valid(vld32s), .overflow(ovf32s));

  mult_accum_pipe #(.NUM_MULT(2), .WIDTH_A(16), .WIDTH_B(16), .WIDTH_RESULT(32), .SATURATE(0)) dut32w (
    .clock0(clock0), .aclr0(aclr0), .ena0(ena0), .in_valid(in_valid),
    .dataa(dataa), .datab(datab), .signa(signa), .signb(signb), .addnsub(addnsub),
    .accum_en(accum_en), .accum_sload(accum_sload),
    .result(res32w), .out_valid(vld32w), .overflow(ovf32w));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: per-instance accumulator as plain integers
  int     wr_of  [3] = '{40, 32, 32};
  bit     sat_of [3] = '{1'b0, 1'b1, 1'b0};
  longint acc_m   [3];
  longint shown_r [3];
  bit     shown_o [3];

  typedef struct packed {
    logic [2:0][63:0] r;
    logic [2:0]       o;
    logic [31:0]      due;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   ecount = 0;
  bit   last_en = 1'b0;
  bit   prev_ov = 1'b0;
  bit   due_now;

  function automatic longint lane(input logic [15:0] v, input bit s);
    if (s) return longint'($signed(v));
    return longint'({48'd0, v});
  endfunction

  task automatic model_push();
    exp_t   e;
    longint s, p1, prev, nxt, lo, hi, one, mask;
    bit     sg, ov;
    one = 1;
    s  = lane(dataa[15:0], signa) * lane(datab[15:0], signb);
    p1 = lane(dataa[31:16], signa) * lane(datab[31:16], signb);
    s  = addnsub[0] ? s + p1 : s - p1;
    sg = signa | signb;
    e  = '0;
    for (int k = 0; k < 3; k++) begin
      mask = (one <<< wr_of[k]) - 1;
      prev = acc_m[k];
      if (sg && prev[wr_of[k]-1]) prev = prev - (one <<< wr_of[k]);
      nxt = (accum_sload || !accum_en) ? s : prev + s;
      if (sg) begin
        lo = -(one <<< (wr_of[k] - 1));
        hi = (one <<< (wr_of[k] - 1)) - 1;
      end else begin
        lo = 0;
        hi = mask;
      end
      ov = (nxt < lo) || (nxt > hi);
      if (ov && sat_of[k]) nxt = (nxt < lo) ? lo : hi;
      acc_m[k] = nxt & mask;
      e.r[k] = acc_m[k];
      e.o[k] = ov;
    end
    e.due = ecount + 2;
    q.push_back(e);
  endtask

  // Capture side: count enabled edges and feed accepted samples to the model
  always @(posedge clock0) begin
    last_en = aclr0 && ena0;
    if (last_en) begin
      ecount++;
      if (in_valid) model_push();
    end
  end

  // Observe side: outputs are compared away from the active edge
  always @(negedge clock0) begin
    if (aclr0 === 1'b1) begin
      if (last_en) begin
        if (q.size() > 0 && int'(q[0].due) < ecount) begin
          check("latency", ecount, q[0].due);
          void'(q.pop_front());
        end
        due_now = (q.size() > 0) && (int'(q[0].due) == ecount);
        check("out_valid40", vld40, due_now);
        check("out_valid32s", vld32s, due_now);
        check("out_valid32w", vld32w, due_now);
        if (due_now) begin
          e_mon = q.pop_front();
          for (int k = 0; k < 3; k++) begin
            shown_r[k] = e_mon.r[k];
            shown_o[k] = e_mon.o[k];
          end
        end
      end else begin
        check("hold_valid", vld40, prev_ov);
      end
      check("result40", res40, shown_r[0]);
      check("result32s", res32s, shown_r[1]);
      check("result32w", res32w, shown_r[2]);
      check("ovf40", ovf40, shown_o[0]);
      check("ovf32s", ovf32s, shown_o[1]);
      check("ovf32w", ovf32w, shown_o[2]);
      prev_ov = vld40;
    end
  end

  task automatic do_reset();
    in_valid = 1'b0;
    @(negedge clock0);
    #2 aclr0 = 1'b0;
    #1;
    check("rst_result40", res40, 0);
    check("rst_result32", res32s, 0);
    check("rst_valid", vld40, 0);
    check("rst_ovf", ovf32w, 0);
    q.delete();
    for (int k = 0; k < 3; k++) begin
      acc_m[k] = 0;
      shown_r[k] = 0;
      shown_o[k] = 0;
    end
    prev_ov = 1'b0;
    @(negedge clock0);
    aclr0 = 1'b1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit sa, input bit sb,
                      input bit ans, input bit ae, input bit sl);
    in_valid = 1'b1;
    dataa = a;
    datab = b;
    signa = sa;
    signb = sb;
    addnsub = ans;
    accum_en = ae;
    accum_sload = sl;
    @(negedge clock0);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clock0);
  endtask

  localparam logic [31:0] LA  = {16'hFFFC, 16'd3};
  localparam logic [31:0] LB  = {16'd6, 16'd5};
  localparam logic [31:0] BIG = {16'h7FFF, 16'h7FFF};

  initial begin
    do_reset();

    send(LA, LB, 1, 1, 1, 0, 0);
    idle(4);
    check("dir_m9", res40, 64'hFF_FFFF_FFF7);
    check("dir_m9_ovf", ovf40, 0);

    send(LA, LB, 1, 1, 0, 0, 0);
    repeat (4) send(LA, LB, 1, 1, 0, 1, 0);
    idle(4);
    check("dir_195", res40, 195);

    send(BIG, BIG, 1, 1, 1, 0, 1);
    send(BIG, BIG, 1, 1, 1, 1, 0);
    idle(4);
    check("sat_result", res32s, 64'h7FFF_FFFF);
    check("sat_ovf", ovf32s, 1);
    check("wrap_result", res32w, 64'hFFFC_0004);
    check("wrap_ovf", ovf32w, 1);

    send({16'd10, 16'd1}, {16'd1, 16'd1}, 0, 0, 0, 0, 1);
    idle(4);
    check("under_result", res32s, 0);
    check("under_ovf", ovf32s, 1);
    send({16'd0, 16'd2}, {16'd0, 16'd1}, 0, 0, 0, 0, 1);
    idle(4);
    check("sload_result", res32s, 2);
    check("sload_ovf", ovf32s, 0);

    send(LA, LB, 1, 1, 0, 1, 1);
    send(LA, LB, 1, 1, 0, 1, 0);
    send(LA, LB, 1, 1, 0, 1, 0);
    in_valid = 1'b0;
    ena0 = 1'b0;
    repeat (5) @(negedge clock0);
    ena0 = 1'b1;
    idle(5);
    check("freeze_117", res40, 117);

    send(LA, LB, 1, 1, 0, 1, 0);
    send(LA, LB, 1, 1, 0, 1, 0);
    do_reset();
    idle(4);
    send(LA, LB, 1, 1, 1, 1, 0);
    idle(4);
    check("post_rst_acc", res40, 64'hFF_FFFF_FFF7);

    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_reset();
      ena0        = ($urandom_range(0, 9) != 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      dataa       = $urandom;
      datab       = $urandom;
      signa       = 1'($urandom_range(0, 1));
      signb       = 1'($urandom_range(0, 1));
      addnsub     = 1'($urandom_range(0, 1));
      accum_en    = ($urandom_range(0, 9) < 7);
      accum_sload = ($urandom_range(0, 9) == 0);
      @(negedge clock0);
    end
    ena0 = 1'b1;
    idle(6);
    check("queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
